// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding
// AXI4-Lite reads and hands instructions to decode over valid/ready.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst_out_ifu,
    output logic [31:0] pc_out_ifu,
    output logic        is_req_valid_to_idu,
    input  logic        is_req_ready_from_idu,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] target_pc_q, target_pc_d;
    logic        kill_q, kill_d;
    logic        err_q, err_d;
    logic [31:0] redir_pc;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign arvalid             = (state_q == AR);
    assign rready              = (state_q == R);
    assign is_req_valid_to_idu = (state_q == HOLD) && !redirect_valid;
    assign araddr              = fetch_pc_q;
    assign pc_out_ifu          = fetch_pc_q;
    assign inst_out_ifu        = inst_q;
    assign fetch_error         = err_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        inst_d      = inst_q;
        target_pc_d = target_pc_q;
        kill_d      = kill_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                state_d = AR;
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                end
            end
            AR: begin
                if (arready) begin
                    state_d = R;
                end
                // address must stay stable on the bus; remember the target
                if (redirect_valid) begin
                    target_pc_d = redir_pc;
                    kill_d      = 1'b1;
                end
            end
            R: begin
                if (rvalid) begin
                    if (rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (kill_q || redirect_valid) begin
                        fetch_pc_d = redirect_valid ? redir_pc : target_pc_q;
                        kill_d     = 1'b0;
                        state_d    = AR;
                    end else begin
                        inst_d  = rdata;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    target_pc_d = redir_pc;
                    kill_d      = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    state_d    = AR;
                end else if (is_req_ready_from_idu) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = AR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            inst_q      <= 32'd0;
            target_pc_q <= 32'd0;
            kill_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            inst_q      <= inst_d;
            target_pc_q <= target_pc_d;
            kill_q      <= kill_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: bus memory model, scoreboard queues for address
// issue and decode delivery, directed redirect/back-pressure/error cases.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst_out_ifu;
    logic [31:0] pc_out_ifu;
    logic        is_req_valid_to_idu;
    logic        is_req_ready_from_idu;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_error;

    ifu dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .araddr                (araddr),
        .arvalid               (arvalid),
        .arready               (arready),
        .rdata                 (rdata),
        .rresp                 (rresp),
        .rvalid                (rvalid),
        .rready                (rready),
        .inst_out_ifu          (inst_out_ifu),
        .pc_out_ifu            (pc_out_ifu),
        .is_req_valid_to_idu   (is_req_valid_to_idu),
        .is_req_ready_from_idu (is_req_ready_from_idu),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .fetch_error           (fetch_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_ar[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_inst[$];

    int          ar_wait_cfg = 0;
    int          r_wait_cfg = 0;
    logic [31:0] cfg_rdata = 32'h0000_0013;
    logic [1:0]  cfg_rresp = 2'b00;
    logic        cfg_mix = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!is_req_valid_to_idu && n < 60) begin
            tick();
            n++;
        end
        chk1({name, "_valid_timeout"}, is_req_valid_to_idu, 1'b1);
    endtask

    // memory: samples handshakes mid-cycle, updates just after the edge
    initial begin
        logic        hs_ar, hs_r, av, pend;
        logic [31:0] a, cur;
        int          ar_cnt, r_cnt;
        pend = 1'b0; ar_cnt = 0; r_cnt = 0; cur = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            av    = arvalid;
            a     = araddr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0; rvalid = 1'b0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (hs_r) rvalid = 1'b0;
                if (hs_ar) begin
                    pend = 1'b1; r_cnt = 0; cur = a; ar_cnt = 0;
                end else if (av) begin
                    ar_cnt++;
                end
                if (pend && !rvalid) begin
                    if (r_cnt >= r_wait_cfg) begin
                        rvalid = 1'b1;
                        rdata  = cfg_mix ? (cfg_rdata | {cur[15:0], 16'h0})
                                         : cfg_rdata;
                        rresp  = cfg_rresp;
                        pend   = 1'b0;
                    end else begin
                        r_cnt++;
                    end
                end
            end
            arready = (ar_cnt >= ar_wait_cfg);
        end
    end

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL ar_unexpected: got %h expected none",
                                 araddr);
                    end else begin
                        chk("araddr", araddr, exp_ar.pop_front());
                    end
                end
                if (is_req_valid_to_idu && is_req_ready_from_idu) begin
                    if (exp_pc.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL deliver_unexpected: got pc %h expected none",
                                 pc_out_ifu);
                    end else begin
                        chk("deliver_pc", pc_out_ifu, exp_pc.pop_front());
                        chk("deliver_inst", inst_out_ifu, exp_inst.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_inst(input logic [31:0] pc, input logic [31:0] inst);
        exp_pc.push_back(pc);
        exp_inst.push_back(inst);
    endtask

    initial begin
        int t0;
        int n;
        rst_n = 1'b0;
        is_req_ready_from_idu = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        repeat (3) tick();
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_valid", is_req_valid_to_idu, 1'b0);
        chk("rst_araddr", araddr, 32'h8000_0000);
        chk("rst_inst", inst_out_ifu, 32'h0);
        chk1("rst_err", fetch_error, 1'b0);

        // sequential fetch from reset
        exp_ar.push_back(32'h8000_0000);
        exp_ar.push_back(32'h8000_0004);
        exp_ar.push_back(32'h8000_0008);
        exp_ar.push_back(32'h8000_000C);
        push_inst(32'h8000_0000, 32'h0000_0013);
        push_inst(32'h8000_0004, 32'h0004_0013);
        push_inst(32'h8000_0008, 32'h0008_0013);
        rst_n = 1'b1;
        tick();
        chk1("arvalid_first", arvalid, 1'b1);
        wait_valid("seq0");
        t0 = cyc;
        tick();
        wait_valid("seq1");
        chk("rate01", 32'(cyc - t0), 32'd3);
        t0 = cyc;
        tick();
        wait_valid("seq2");
        chk("rate12", 32'(cyc - t0), 32'd3);

        // decode back-pressure
        is_req_ready_from_idu = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("bp_valid", is_req_valid_to_idu, 1'b1);
            chk("bp_pc", pc_out_ifu, 32'h8000_0008);
            chk("bp_inst", inst_out_ifu, 32'h0008_0013);
            chk1("bp_arvalid", arvalid, 1'b0);
        end
        is_req_ready_from_idu = 1'b1;
        tick();
        chk1("bp_next_ar", arvalid, 1'b1);

        // redirect in HOLD with decode ready
        exp_ar.push_back(32'h8000_0100);
        push_inst(32'h8000_0100, 32'h0100_0013);
        wait_valid("hold_c");
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        #1;
        chk1("hold_redir_valid", is_req_valid_to_idu, 1'b0);
        tick();
        redirect_valid = 1'b0;
        chk("hold_redir_addr", araddr, 32'h8000_0100);

        // two redirects while waiting on a slow response
        wait_valid("tgt100");
        r_wait_cfg = 4;
        exp_ar.push_back(32'h8000_0104);
        exp_ar.push_back(32'h8000_0300);
        push_inst(32'h8000_0300, 32'h0300_0013);
        tick();
        tick();
        chk1("r_rready", rready, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        tick();
        redirect_pc = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        n = 0;
        while (!arvalid && n < 20) begin
            chk1("kill_no_valid", is_req_valid_to_idu, 1'b0);
            tick();
            n++;
        end
        r_wait_cfg = 0;
        chk1("kill_ar_timeout", arvalid, 1'b1);
        chk("kill_addr", araddr, 32'h8000_0300);

        // redirect while address is stalled
        wait_valid("tgt300");
        ar_wait_cfg = 3;
        exp_ar.push_back(32'h8000_0304);
        exp_ar.push_back(32'h8000_0400);
        push_inst(32'h8000_0400, 32'h0400_0013);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk1("ar_stall_valid", arvalid, 1'b1);
            chk("ar_stall_addr", araddr, 32'h8000_0304);
            redirect_valid = (i == 1);
            redirect_pc = 32'h8000_0400;
            tick();
        end
        redirect_valid = 1'b0;
        ar_wait_cfg = 0;

        // error response is delivered and sticky
        wait_valid("tgt400");
        cfg_mix = 1'b0;
        cfg_rdata = 32'h0010_0073;
        cfg_rresp = 2'b10;
        exp_ar.push_back(32'h8000_0404);
        push_inst(32'h8000_0404, 32'h0010_0073);
        tick();
        wait_valid("err");
        chk1("err_set", fetch_error, 1'b1);
        cfg_mix = 1'b1;
        cfg_rdata = 32'h0000_0013;
        cfg_rresp = 2'b00;
        exp_ar.push_back(32'h8000_0408);
        push_inst(32'h8000_0408, 32'h0408_0013);
        tick();
        wait_valid("after_err");
        chk1("err_sticky", fetch_error, 1'b1);
        tick();
        chk1("pre_rst_ar", arvalid, 1'b1);

        // reset mid-transaction
        rst_n = 1'b0;
        #1;
        chk1("rst2_arvalid", arvalid, 1'b0);
        chk("rst2_araddr", araddr, 32'h8000_0000);
        chk1("rst2_err", fetch_error, 1'b0);
        chk("rst2_inst", inst_out_ifu, 32'h0);
        tick();
        tick();
        exp_ar.push_back(32'h8000_0000);
        push_inst(32'h8000_0000, 32'h0000_0013);
        rst_n = 1'b1;
        tick();
        wait_valid("post_rst");
        ar_wait_cfg = 1000;
        chk1("post_rst_err", fetch_error, 1'b0);
        repeat (4) tick();
        chk("ar_q_empty", 32'(exp_ar.size()), 32'd0);
        chk("inst_q_empty", 32'(exp_pc.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
